// File: rtl/cpu_bus_pkg.sv
// Shared CPU-board bus definitions: bus word width, word type and byte-swap helper.
// Used by the CD store driver and the CD load holding buffer.
package cpu_bus_pkg;

    localparam int BUS_DW = 16;

    typedef logic [BUS_DW-1:0] busWord_t;

    function automatic busWord_t byteSwap(input busWord_t word);
        return {word[7:0], word[15:8]};
    endfunction

endpackage

// File: rtl/cpu_ldcd_36_if.sv
// CD-load / IDB bus bundle. The master drives strobes and CD data; the slave
// (cpu_ldcd_36) returns the IDB word and buffer status.
interface cpu_ldcd_36_if
    import cpu_bus_pkg::*;
#(
    parameter int DW    = BUS_DW,
    parameter int DEPTH = 2
);

    logic [DW-1:0]            CD_15_0;
    logic                     LCD_n;
    logic                     BSWAP;
    logic                     EIDB_n;
    logic                     IDB_POP;
    logic                     CLR_OVR;
    logic [DW-1:0]            IDB_15_0;
    logic                     IDB_OE;
    logic                     EMPTY;
    logic                     FULL;
    logic                     OVR;
    logic [$clog2(DEPTH):0]   CNT;

    modport master (
        output CD_15_0, LCD_n, BSWAP, EIDB_n, IDB_POP, CLR_OVR,
        input  IDB_15_0, IDB_OE, EMPTY, FULL, OVR, CNT
    );

    modport slave (
        input  CD_15_0, LCD_n, BSWAP, EIDB_n, IDB_POP, CLR_OVR,
        output IDB_15_0, IDB_OE, EMPTY, FULL, OVR, CNT
    );

endinterface

// File: rtl/cpu_ldcd_fifo.sv
// Holding-buffer core: circular storage with read/write pointers and occupancy count.
// A push is accepted when a slot is free or a pop frees one in the same cycle.
module cpu_ldcd_fifo
    import cpu_bus_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = BUS_DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pushEn,
    input  logic [DW-1:0]           pushData,
    input  logic                    popEn,
    output logic [DW-1:0]           headData,
    output logic [$clog2(DEPTH):0]  cnt,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wrPtr_r;
    logic [AW-1:0] rdPtr_r;
    logic [CW-1:0] cnt_r;
    logic          empty_s;
    logic          full_s;
    logic          popOk_s;
    logic          pushOk_s;

    // Status decode and push/pop acceptance.
    always_comb begin
        empty_s  = (cnt_r == {CW{1'b0}});
        full_s   = (cnt_r == CW'(DEPTH));
        popOk_s  = popEn & ~empty_s;
        pushOk_s = pushEn & (~full_s | popOk_s);
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (pushOk_s) begin
            mem_r[wrPtr_r] <= pushData;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            if (pushOk_s) begin
                wrPtr_r <= wrPtr_r + AW'(1);
            end
            if (popOk_s) begin
                rdPtr_r <= rdPtr_r + AW'(1);
            end
            case ({pushOk_s, popOk_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign headData = mem_r[rdPtr_r];
    assign cnt      = cnt_r;
    assign empty    = empty_s;
    assign full     = full_s;

endmodule

// File: rtl/cpu_ldcd_36.sv
// CD load holding buffer: captures CD bus words on each LCD_n falling edge (optionally
// byte-swapped) and presents the oldest word on the IDB under EIDB_n.
module cpu_ldcd_36
    import cpu_bus_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = BUS_DW
) (
    input  logic               sysclk,
    input  logic               sys_rst,
    cpu_ldcd_36_if.slave       bus
);

    logic                    lcdQ_r;
    logic                    ovr_r;
    logic                    pushReq_s;
    logic                    overflow_s;
    logic [DW-1:0]           pushData_s;
    logic [DW-1:0]           headData_s;
    logic [$clog2(DEPTH):0]  cnt_s;
    logic                    empty_s;
    logic                    full_s;
    logic                    idbOe_s;
    logic [DW-1:0]           idbData_s;

    // Strobe edge detect, write data selection and overflow detection.
    always_comb begin
        pushReq_s = ~bus.LCD_n & lcdQ_r;
        if (bus.BSWAP) begin
            pushData_s = byteSwap(bus.CD_15_0);
        end else begin
            pushData_s = bus.CD_15_0;
        end
        // A full buffer always has a head, so a coincident pop always frees a slot.
        overflow_s = pushReq_s & full_s & ~bus.IDB_POP;
    end

    // LCD_n history and sticky overflow flag; a new overflow wins over a clear.
    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            lcdQ_r <= 1'b1;
            ovr_r  <= 1'b0;
        end else begin
            lcdQ_r <= bus.LCD_n;
            if (overflow_s) begin
                ovr_r <= 1'b1;
            end else if (bus.CLR_OVR) begin
                ovr_r <= 1'b0;
            end else begin
                ovr_r <= ovr_r;
            end
        end
    end

    cpu_ldcd_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk      (sysclk),
        .rst      (sys_rst),
        .pushEn   (pushReq_s),
        .pushData (pushData_s),
        .popEn    (bus.IDB_POP),
        .headData (headData_s),
        .cnt      (cnt_s),
        .empty    (empty_s),
        .full     (full_s)
    );

    // IDB drive gating: the bus is released to zero unless enabled with data present.
    always_comb begin
        idbOe_s = ~bus.EIDB_n & ~empty_s;
        if (idbOe_s) begin
            idbData_s = headData_s;
        end else begin
            idbData_s = {DW{1'b0}};
        end
    end

    assign bus.IDB_15_0 = idbData_s;
    assign bus.IDB_OE   = idbOe_s;
    assign bus.EMPTY    = empty_s;
    assign bus.FULL     = full_s;
    assign bus.OVR      = ovr_r;
    assign bus.CNT      = cnt_s;

endmodule
